regfile_write_arbiter: RTL

Round-robin arbiter that shares the single write port of the team's `register_file` (default 8-bit words, 16 entries) among several requesters. Each requester presents an address/data pair under a valid/ready handshake. The arbiter grants at most one requester per cycle and drives a registered `write_en`/`write_addr`/`data_in` triple straight into the register file's write port. It sits between the requesting pipeline stages and the register file.

---
 rtl/regfile_write_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register file's single write port among
// several valid/ready requesters and drives a registered write triple.
module regfile_write_arbiter #(
  parameter int WORD_LEN  = 8,
  parameter int ADDR_LEN  = 4,
  parameter int REQ_COUNT = 4,
  parameter int ID_LEN    = $clog2(REQ_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [REQ_COUNT-1:0]          req_valid,
  input  logic [REQ_COUNT*ADDR_LEN-1:0] req_addr,
  input  logic [REQ_COUNT*WORD_LEN-1:0] req_data,
  output logic [REQ_COUNT-1:0]          req_ready,
  output logic                          write_en,
  output logic [ADDR_LEN-1:0]           write_addr,
  output logic [WORD_LEN-1:0]           data_in,
  output logic [ID_LEN-1:0]             grant_id,
  output logic                          grant_valid
);

  // One extra bit so rr_ptr + offset never overflows before the wrap correction.
  localparam int IDX_W = ID_LEN + 1;

  logic [ID_LEN-1:0]   rr_ptr;
  logic [ID_LEN-1:0]   winner;
  logic [ID_LEN-1:0]   next_ptr;
  logic                found;
  logic                transfer;
  logic [IDX_W-1:0]    idx;
  logic [ADDR_LEN-1:0] sel_addr;
  logic [WORD_LEN-1:0] sel_data;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      idx = {1'b0, rr_ptr} + IDX_W'(k);
      if (idx >= IDX_W'(REQ_COUNT)) begin
        idx = idx - IDX_W'(REQ_COUNT);
      end
      if (!found && req_valid[idx[ID_LEN-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_LEN-1:0];
      end
    end
  end

  // The ready path depends only on valid, stall, rst and the pointer, never on addr/data.
  always_comb begin
    req_ready = '0;
    if (found && !stall && !rst) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign transfer = |(req_ready & req_valid);
  assign next_ptr = (winner == ID_LEN'(REQ_COUNT - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (winner == ID_LEN'(i)) begin
        sel_addr = req_addr[i*ADDR_LEN +: ADDR_LEN];
        sel_data = req_data[i*WORD_LEN +: WORD_LEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      write_en   <= 1'b0;
      write_addr <= '0;
      data_in    <= '0;
      grant_id   <= '0;
    end else begin
      write_en <= transfer;
      if (transfer) begin
        write_addr <= sel_addr;
        data_in    <= sel_data;
        grant_id   <= winner;
        rr_ptr     <= next_ptr;
      end
    end
  end

  assign grant_valid = write_en;

endmodule
